// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, edge/bit counters and frame FSM.
// Steers the sampler and deserializer and reports per-frame status.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic [5:0] prescale,
   input  logic       par_en,
   input  logic       par_typ,
   input  logic       sampled_bit,
   output logic       sampler_en,
   output logic [5:0] edge_count,
   output logic [3:0] bit_count,
   output logic       deser_en,
   output logic       data_valid,
   output logic       par_err,
   output logic       stp_err,
   output logic       strt_glitch
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0] state;
   logic [5:0] prescale_q;
   logic       par_en_q;
   logic       par_typ_q;
   logic       acc;
   logic       bit_end;

   // ">=" rather than "==" so a bad prescale can never strand the counter
   assign bit_end    = (edge_count >= (prescale_q - 6'd1));
   assign sampler_en = (state != IDLE);
   assign deser_en   = (state == DATA);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         edge_count  <= '0;
         bit_count   <= '0;
         prescale_q  <= '0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 1'b0;
         acc         <= 1'b0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         strt_glitch <= 1'b0;
         if (state == IDLE) begin
            edge_count <= '0;
            bit_count  <= '0;
            if (!rx_in) begin
               state      <= START;
               par_err    <= 1'b0;
               stp_err    <= 1'b0;
               acc        <= 1'b0;
               prescale_q <= prescale;
               par_en_q   <= par_en;
               par_typ_q  <= par_typ;
            end
         end else begin
            if (bit_end) begin
               edge_count <= '0;
               bit_count  <= bit_count + 4'd1;
            end else begin
               edge_count <= edge_count + 6'd1;
            end
            case (state)
               START: if (bit_end) begin
                  if (sampled_bit) begin
                     strt_glitch <= 1'b1;
                     state       <= IDLE;
                     bit_count   <= '0;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: if (bit_end) begin
                  acc <= acc ^ sampled_bit;
                  if (bit_count == 4'(DATA_WIDTH))
                     state <= par_en_q ? PARITY : STOP;
               end
               PARITY: if (bit_end) begin
                  par_err <= (sampled_bit != (acc ^ par_typ_q));
                  state   <= STOP;
               end
               STOP: if (bit_end) begin
                  stp_err    <= ~sampled_bit;
                  data_valid <= sampled_bit & ~par_err;
                  state      <= IDLE;
                  bit_count  <= '0;
               end
               default: begin
                  state      <= IDLE;
                  edge_count <= '0;
                  bit_count  <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of whole frames plus glitch,
// back-to-back and mid-frame reset sequences. The bench acts as the sampler.
module tb_uart_rx_ctrl;

   localparam int DW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [5:0] prescale;
   logic       par_en;
   logic       par_typ;
   logic       sampled_bit;
   logic       sampler_en;
   logic [5:0] edge_count;
   logic [3:0] bit_count;
   logic       deser_en;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;
   logic       strt_glitch;

   uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
      .par_en(par_en), .par_typ(par_typ), .sampled_bit(sampled_bit),
      .sampler_en(sampler_en), .edge_count(edge_count), .bit_count(bit_count),
      .deser_en(deser_en), .data_valid(data_valid), .par_err(par_err),
      .stp_err(stp_err), .strt_glitch(strt_glitch)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;

   // Output monitor on the falling edge
   int cyc = 0, dv_cnt = 0, gl_cnt = 0, deser_cnt = 0;
   int dv_last = 0, dv_prev = 0, start_cyc = 0;
   logic prev_sen = 1'b0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (data_valid === 1'b1) begin
         dv_cnt  = dv_cnt + 1;
         dv_prev = dv_last;
         dv_last = cyc;
      end
      if (strt_glitch === 1'b1) gl_cnt = gl_cnt + 1;
      if (deser_en === 1'b1) deser_cnt = deser_cnt + 1;
      if (sampler_en === 1'b1 && !prev_sen) start_cyc = cyc;
      prev_sen = (sampler_en === 1'b1);
   end

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else passed = passed + 1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int p);
      rx_in       = b;
      sampled_bit = b;
      repeat (p) tick();
   endtask

   task automatic idle(input int n);
      rx_in       = 1'b1;
      sampled_bit = 1'b1;
      repeat (n) tick();
   endtask

   // Returns right after the stop-bit decision edge (DUT back in IDLE)
   task automatic send_frame(input int p, input logic pe, input logic pt,
                             input logic [7:0] d, input logic pb, input logic sb);
      prescale = p[5:0];
      par_en   = pe;
      par_typ  = pt;
      rx_in    = 1'b0;
      sampled_bit = 1'b0;
      tick();
      drive_bit(1'b0, p);
      for (int i = 0; i < DW; i++) drive_bit(d[i], p);
      if (pe) drive_bit(pb, p);
      drive_bit(sb, p);
   endtask

   typedef struct {
      int         p;
      logic       pe;
      logic       pt;
      logic [7:0] d;
      logic       pb;
      logic       sb;
      int         exp_dv;
      int         exp_pe;
      int         exp_se;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int b_dv, b_gl, b_de;
      vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0};
      vecs[1] = '{8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 0, 1, 0};
      vecs[2] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 0, 1};
      vecs[3] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0};
      vecs[4] = '{32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1, 0, 0};
      vecs[5] = '{8,  1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, 1};
      vecs[6] = '{16, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 1};

      rst = 1'b0; rx_in = 1'b1; sampled_bit = 1'b1;
      prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", int'({sampler_en, edge_count, bit_count, deser_en,
                                 data_valid, par_err, stp_err, strt_glitch}), 0);
      rst = 1'b1;
      idle(2);
      chk("idle_hold", int'({sampler_en, edge_count, bit_count}), 0);

      for (int v = 0; v < 7; v++) begin
         b_dv = dv_cnt; b_gl = gl_cnt; b_de = deser_cnt;
         send_frame(vecs[v].p, vecs[v].pe, vecs[v].pt, vecs[v].d, vecs[v].pb, vecs[v].sb);
         idle(4);
         chk($sformatf("v%0d_dv", v), dv_cnt - b_dv, vecs[v].exp_dv);
         chk($sformatf("v%0d_par_err", v), int'(par_err), vecs[v].exp_pe);
         chk($sformatf("v%0d_stp_err", v), int'(stp_err), vecs[v].exp_se);
         chk($sformatf("v%0d_deser_cycles", v), deser_cnt - b_de, DW * vecs[v].p);
         chk($sformatf("v%0d_glitch", v), gl_cnt - b_gl, 0);
         chk($sformatf("v%0d_idle", v), int'({sampler_en, edge_count, bit_count}), 0);
         if (vecs[v].exp_dv == 1)
            chk($sformatf("v%0d_latency", v), dv_last - start_cyc,
                (DW + 2 + int'(vecs[v].pe)) * vecs[v].p);
      end

      // Start glitch: line low for 3 cycles only
      b_dv = dv_cnt; b_gl = gl_cnt; b_de = deser_cnt;
      prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
      rx_in = 1'b0; sampled_bit = 1'b0;
      repeat (3) tick();
      idle(12);
      chk("glitch_pulse", gl_cnt - b_gl, 1);
      chk("glitch_deser", deser_cnt - b_de, 0);
      chk("glitch_dv", dv_cnt - b_dv, 0);
      chk("glitch_idle", int'({sampler_en, edge_count, bit_count}), 0);

      // Back-to-back frames, odd parity, next start on first idle cycle
      b_dv = dv_cnt;
      send_frame(32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
      send_frame(32, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b1);
      idle(4);
      chk("b2b_dv", dv_cnt - b_dv, 2);
      // 11*32 frame plus the single IDLE cycle that detects the next start
      chk("b2b_spacing", dv_last - dv_prev, 353);
      chk("b2b_errs", int'({par_err, stp_err}), 0);

      // Reset in the middle of data bit 4
      b_dv = dv_cnt;
      prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
      rx_in = 1'b0; sampled_bit = 1'b0;
      tick();
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      rx_in = 1'b0; sampled_bit = 1'b0;
      repeat (2) tick();
      chk("pre_rst_bit", int'(bit_count), 4);
      chk("pre_rst_deser", int'(deser_en), 1);
      rst = 1'b0;
      tick();
      chk("mid_rst_outputs", int'({sampler_en, edge_count, bit_count, deser_en,
                                   data_valid, par_err, stp_err, strt_glitch}), 0);
      rst = 1'b1;
      idle(2);
      chk("mid_rst_no_dv", dv_cnt - b_dv, 0);
      send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
      idle(3);
      chk("post_rst_dv", dv_cnt - b_dv, 1);
      chk("post_rst_errs", int'({par_err, stp_err}), 0);
      chk("post_rst_latency", dv_last - start_cyc, 10 * 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
